sha1_msg_padder: RTL

//  Producer side of the SHA-1 message-word interface: takes a raw big-endian 32-bit message stream and emits

---
 rtl/sha1_msg_padder_pkg.sv | 31 +++
 rtl/sha1_msg_padder_if.sv | 34 +++
 rtl/sha1_pad_mask.sv | 32 +++
 rtl/sha1_msg_padder.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/sha1_msg_padder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha1_msg_padder_pkg
//  Description : Shared SHA-1 message-padding constants, padder state
//                encoding and small helpers. Also used by the compression
//                core control logic.
//  Revision    : 1.0  initial release
// ============================================================================
package sha1_msg_padder_pkg;

    localparam logic [31:0] SHA1_PAD_WORD     = 32'h8000_0000;
    localparam int          SHA1_BLK_WORDS    = 16;
    localparam int          SHA1_IDX_W        = $clog2(SHA1_BLK_WORDS);
    localparam logic [3:0]  SHA1_LAST_PAD_IDX = 4'd13;
    localparam logic [3:0]  SHA1_LEN_HI_IDX   = 4'd14;
    localparam logic [3:0]  SHA1_LEN_LO_IDX   = 4'd15;

    typedef enum logic [1:0] {
        ST_DATA   = 2'd0,
        ST_PAD    = 2'd1,
        ST_LEN_HI = 2'd2,
        ST_LEN_LO = 2'd3
    } pad_state_t;

    // Byte counts above 4 on the final word mean "whole word".
    function automatic logic [2:0] sat_nbytes(input logic [2:0] n);
        return (n > 3'd4) ? 3'd4 : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha1_msg_padder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha1_msg_padder_if
//  Description : Message-stream input and padded-word output bundle.
//                master : the padder (accepts message words, drives blocks)
//                slave  : host / consumer side
//  Revision    : 1.0  initial release
// ============================================================================
interface sha1_msg_padder_if;
    import sha1_msg_padder_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_data;
    logic                  in_last;
    logic [2:0]            in_nbytes;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_data;
    logic [SHA1_IDX_W-1:0] out_idx;
    logic                  out_blk_last;
    logic                  out_msg_last;

    modport master (
        input  in_valid, in_data, in_last, in_nbytes, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_blk_last, out_msg_last
    );

    modport slave (
        output in_valid, in_data, in_last, in_nbytes, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_blk_last, out_msg_last
    );
endinterface
`default_nettype wire

// File: rtl/sha1_pad_mask.sv
`default_nettype none
// ============================================================================
//  Module      : sha1_pad_mask
//  Description : Combinational final-word builder. Keeps bytes 0..k-1 of the
//                big-endian word, puts the 0x80 marker in byte k and clears
//                the rest. k>=4 passes the word through unchanged.
//  Ports       : i_data   message word, byte 0 in [31:24]
//                i_nbytes valid byte count k
//                o_word   masked word
//  Revision    : 1.0  initial release
// ============================================================================
module sha1_pad_mask
    import sha1_msg_padder_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_nbytes,
    output logic [31:0] o_word
);

    always_comb begin
        o_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < i_nbytes) begin
                o_word[31-8*b -: 8] = i_data[31-8*b -: 8];
            end else if (3'(b) == i_nbytes) begin
                o_word[31-8*b -: 8] = 8'h80;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sha1_msg_padder.sv
`default_nettype none
// ============================================================================
//  Module      : sha1_msg_padder
//  Description : Turns a big-endian 32-bit message stream into padded 512-bit
//                SHA-1 blocks, emitted as 16 sequential words with index.
//  Ports       : clk, rst (async, active-high)
//                bus.in_*  message words (valid/ready, last, byte count)
//                bus.out_* padded words (valid/ready, idx, block/msg last)
//  Revision    : 1.0  initial release
// ============================================================================
module sha1_msg_padder
    import sha1_msg_padder_pkg::*;
#(
    parameter int LEN_W = 64
)(
    input  logic               clk,
    input  logic               rst,
    sha1_msg_padder_if.master  bus
);

    pad_state_t            r_state, w_state_nxt;
    logic                  r_pend, w_pend_nxt;       // next PAD word is the 0x80 word
    logic [LEN_W-1:0]      r_len, w_len_nxt;
    logic [SHA1_IDX_W-1:0] r_nidx;                   // index the next loaded word gets
    logic                  r_out_valid;
    logic [31:0]           r_out_data;
    logic [SHA1_IDX_W-1:0] r_out_idx;
    logic                  r_out_msg_last;

    logic                  w_load_ok, w_in_fire, w_load, w_msg_last;
    logic [31:0]           w_word, w_masked;
    logic [2:0]            w_k;
    logic [5:0]            w_len_add;
    logic [63:0]           w_len64;

    // Output register may be (re)loaded when empty or being drained.
    assign w_load_ok = !r_out_valid || bus.out_ready;
    assign w_in_fire = bus.in_valid && bus.in_ready;
    assign w_k       = sat_nbytes(bus.in_nbytes);
    assign w_len_add = bus.in_last ? {w_k, 3'b000} : 6'd32;
    assign w_len64   = 64'(r_len);

    sha1_pad_mask u_mask (
        .i_data   (bus.in_data),
        .i_nbytes (w_k),
        .o_word   (w_masked)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_len_nxt   = r_len;
        w_load      = 1'b0;
        w_word      = '0;
        w_msg_last  = 1'b0;
        case (r_state)
            ST_DATA: begin
                if (w_in_fire) begin
                    w_load    = 1'b1;
                    w_len_nxt = r_len + LEN_W'(w_len_add);
                    w_word    = bus.in_last ? w_masked : bus.in_data;
                    if (bus.in_last) begin
                        if (w_k == 3'd4) begin
                            // Marker did not fit; it becomes the next word.
                            w_pend_nxt  = 1'b1;
                            w_state_nxt = ST_PAD;
                        end else if (r_nidx == SHA1_LAST_PAD_IDX) begin
                            w_state_nxt = ST_LEN_HI;
                        end else begin
                            w_state_nxt = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (w_load_ok) begin
                    w_load     = 1'b1;
                    w_word     = r_pend ? SHA1_PAD_WORD : 32'h0;
                    w_pend_nxt = 1'b0;
                    // Only idx 13 leads to the length; 14/15 wrap into a new block.
                    if (r_nidx == SHA1_LAST_PAD_IDX) begin
                        w_state_nxt = ST_LEN_HI;
                    end
                end
            end
            ST_LEN_HI: begin
                if (w_load_ok) begin
                    w_load      = 1'b1;
                    w_word      = w_len64[63:32];
                    w_state_nxt = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_load_ok) begin
                    w_load      = 1'b1;
                    w_word      = w_len64[31:0];
                    w_msg_last  = 1'b1;
                    w_len_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end
            end
            default: w_state_nxt = ST_DATA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_DATA;
            r_pend         <= 1'b0;
            r_len          <= '0;
            r_nidx         <= '0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_idx      <= '0;
            r_out_msg_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_len   <= w_len_nxt;
            if (w_load) begin
                r_out_valid    <= 1'b1;
                r_out_data     <= w_word;
                r_out_idx      <= r_nidx;
                r_out_msg_last <= w_msg_last;
                r_nidx         <= r_nidx + 1'b1;
            end else if (w_load_ok) begin
                r_out_valid    <= 1'b0;
            end
        end
    end

    assign bus.in_ready     = (r_state == ST_DATA) && w_load_ok;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_idx      = r_out_idx;
    assign bus.out_blk_last = (r_out_idx == SHA1_LEN_LO_IDX);
    assign bus.out_msg_last = r_out_msg_last;

endmodule
`default_nettype wire
